instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/riscv_pkg.sv | 17 +
 rtl/instr_encoder_if.sv | 31 +++
 rtl/enc_fifo.sv | 59 +++++
 rtl/instr_encoder.sv | 176 +++++++++++++++++
 tb/tb_instr_encoder.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding constants: major opcodes and the instruction-class code
// used by the encoder and the main decoder.
package riscv_pkg;

  typedef enum logic [1:0] {
    CLS_LOAD   = 2'b00,
    CLS_STORE  = 2'b01,
    CLS_RTYPE  = 2'b10,
    CLS_BRANCH = 2'b11
  } instr_cls_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/instr_encoder_if.sv
// Instruction-field handshake and memory write bus of the instruction encoder.
// The slave side is the encoder; the master side is the producer/memory.
interface instr_encoder_if;

  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_cls;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [12:0] in_imm;
  logic        mem_we;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output in_valid, in_cls, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_cls, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/enc_fifo.sv
// Synchronous power-of-two FIFO holding encoded instruction words.
// Push while full and pop while empty are ignored; reset flushes the contents.
module enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Depth is a power of two, so the count MSB alone marks full.
  assign o_full    = r_count[AW];
  assign o_empty   = (r_count == '0);
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes instruction fields into 32-bit RISC-V words and streams them to memory.
// Optional build macro IENC_RANGE_CHECK_EN enables immediate range checking (err).
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_RUN   | accepting instructions, writing words
// ST_DRAIN | no more input, flushing FIFO and output register
// ST_DONE  | one-cycle completion, done pulse
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           base_addr,
  input  logic                  finish,
  instr_encoder_if.slave        bus,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            count,
  output logic                  err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  state_e      r_state;
  logic        r_busy;
  logic        r_done;
  logic [7:0]  r_count;
  logic [31:0] r_next_addr;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  instr_cls_e  w_cls;
  logic [31:0] w_word;
  logic [31:0] w_fifo_data;
  logic        w_full;
  logic        w_empty;
  logic        w_in_ready;
  logic        w_hs;
  logic        w_push;
  logic        w_pop;
  logic        w_wr_accept;

  assign w_cls       = instr_cls_e'(bus.in_cls);
  assign w_in_ready  = (r_state == ST_RUN) && !w_full;
  assign w_hs        = bus.in_valid && w_in_ready;
  assign w_wr_accept = r_mem_we && bus.mem_ready;
  // Refill the output register whenever it is empty or being accepted this edge.
  assign w_pop       = !w_empty && (!r_mem_we || bus.mem_ready);

  always_comb begin
    w_word = '0;
    case (w_cls)
      CLS_LOAD:   w_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_LOAD};
      CLS_STORE:  w_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                            bus.in_imm[4:0], OP_STORE};
      CLS_RTYPE:  w_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                            bus.in_rd, OP_RTYPE};
      default:    w_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                            bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11], OP_BRANCH};
    endcase
  end

`ifdef IENC_RANGE_CHECK_EN
  logic r_err;
  logic w_bad;

  // Branch offsets must be even; load/store offsets must fit in 12 signed bits.
  assign w_bad  = ((w_cls == CLS_BRANCH) && bus.in_imm[0]) ||
                  (((w_cls == CLS_LOAD) || (w_cls == CLS_STORE)) &&
                   (bus.in_imm[12] != bus.in_imm[11]));
  assign w_push = w_hs && !w_bad;
  assign err    = r_err;
`else
  assign w_push = w_hs;
  assign err    = 1'b0;
`endif

  enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_word),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_count     <= '0;
      r_next_addr <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
`ifdef IENC_RANGE_CHECK_EN
      r_err       <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;

      if (w_pop) begin
        r_mem_we    <= 1'b1;
        r_mem_addr  <= r_next_addr;
        r_mem_wdata <= w_fifo_data;
        r_next_addr <= r_next_addr + 32'd4;
      end else if (w_wr_accept) begin
        r_mem_we <= 1'b0;
      end

      if (w_wr_accept && (r_count != 8'hFF)) begin
        r_count <= r_count + 8'd1;
      end

`ifdef IENC_RANGE_CHECK_EN
      if (w_hs && w_bad) begin
        r_err <= 1'b1;
      end
`endif

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_RUN;
            r_busy      <= 1'b1;
            r_count     <= '0;
            r_next_addr <= base_addr & ~32'h3;
`ifdef IENC_RANGE_CHECK_EN
            r_err       <= 1'b0;
`endif
          end
        end
        ST_RUN: begin
          if (finish) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_empty && (!r_mem_we || bus.mem_ready)) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign busy          = r_busy;
  assign done          = r_done;
  assign count         = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-computed encodings, write ordering,
// backpressure, address wrap, reset mid-session and the optional range check.
module tb_instr_encoder;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        finish;
  logic [31:0] base_addr;
  logic        busy;
  logic        done;
  logic [7:0]  count;
  logic        err;

  instr_encoder_if ifc ();

  instr_encoder #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .finish    (finish),
    .bus       (ifc),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int hs_cyc  = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          wr_cyc_q  [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ifc.in_valid && ifc.in_ready) hs_cyc = cyc;
    if (ifc.mem_we && ifc.mem_ready) begin
      wr_addr_q.push_back(ifc.mem_addr);
      wr_data_q.push_back(ifc.mem_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (done) begin
      done_cyc = cyc;
      done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    done_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    finish = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_log();
  endtask

  task automatic pulse_start(input logic [31:0] base);
    base_addr = base;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    @(posedge clk);
    #1;
    finish = 1'b0;
  endtask

  task automatic set_fields(input logic [1:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [12:0] imm);
    ifc.in_cls    = cls;
    ifc.in_rd     = rd;
    ifc.in_rs1    = rs1;
    ifc.in_rs2    = rs2;
    ifc.in_funct3 = f3;
    ifc.in_funct7 = f7;
    ifc.in_imm    = imm;
  endtask

  task automatic send(input logic [1:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [12:0] imm, input bit fin);
    bit ok = 0;
    bit rdy;
    set_fields(cls, rd, rs1, rs2, f3, f7, imm);
    ifc.in_valid = 1'b1;
    finish = fin;
    for (int i = 0; i < 20 && !ok; i++) begin
      rdy = ifc.in_ready;
      @(posedge clk);
      #1;
      if (rdy) ok = 1;
    end
    ifc.in_valid = 1'b0;
    finish = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int c0 = done_cnt;
    for (int i = 0; i < 60 && done_cnt == c0; i++) @(posedge clk);
    #1;
    chk({tag, "_done_seen"}, 32'(done_cnt != c0), 32'd1);
  endtask

  logic [31:0] exp1_data [4] = '{32'h0084A283, 32'h0064A423, 32'h002081B3, 32'hFE208EE3};
  logic [31:0] exp2_data [5] = '{32'h000000B3, 32'h00000133, 32'h000001B3, 32'h00000233, 32'h000002B3};
  logic [31:0] exp3_data [3] = '{32'h00000083, 32'h00000103, 32'h00000183};

  initial begin
    int h0;
    int idx;
    bit acc;

    base_addr = '0;
    set_fields(2'b00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
    ifc.mem_ready = 1'b0;
    ifc.in_valid = 1'b0;

    // Reset state, sampled while rst is still held.
    rst = 1'b1;
    start = 1'b0;
    finish = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_we", 32'(ifc.mem_we), 32'd0);
    chk("rst_mem_addr", ifc.mem_addr, 32'd0);
    chk("rst_mem_wdata", ifc.mem_wdata, 32'd0);
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    do_reset();

    // Encoding of all four classes, first-write latency, start ignored in RUN.
    ifc.mem_ready = 1'b1;
    pulse_start(32'h0000_0100);
    chk("s1_busy", 32'(busy), 32'd1);
    chk("s1_in_ready", 32'(ifc.in_ready), 32'd1);
    send(2'b00, 5'd5, 5'd9, 5'd0, 3'b010, 7'd0, 13'd8, 1'b0);
    h0 = hs_cyc;
    chk("s1_we_early", 32'(ifc.mem_we), 32'd0);
    @(posedge clk);
    #1;
    chk("s1_we_n2", 32'(ifc.mem_we), 32'd1);
    chk("s1_addr_n2", ifc.mem_addr, 32'h0000_0100);
    chk("s1_data_n2", ifc.mem_wdata, 32'h0084A283);
    pulse_start(32'h0000_0500);
    send(2'b01, 5'd0, 5'd9, 5'd6, 3'b010, 7'd0, 13'd8, 1'b0);
    send(2'b10, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 13'd0, 1'b0);
    send(2'b11, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 13'h1FFC, 1'b1);
    wait_done("s1");
    chk("s1_nwr", 32'(wr_addr_q.size()), 32'd4);
    if (wr_addr_q.size() == 4) begin
      chk("s1_latency", 32'(wr_cyc_q[0] - h0), 32'd2);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("s1_addr%0d", i), wr_addr_q[i], 32'h100 + 32'(4 * i));
        chk($sformatf("s1_data%0d", i), wr_data_q[i], exp1_data[i]);
      end
    end
    chk("s1_count", 32'(count), 32'd4);
    repeat (3) @(posedge clk);
    #1;
    chk("s1_done_pulses", 32'(done_cnt), 32'd1);
    chk("s1_busy_end", 32'(busy), 32'd0);

    // Backpressure: 6 back-to-back valids with the memory stalled.
    do_reset();
    pulse_start(32'h0000_0100);
    idx = 0;
    set_fields(2'b10, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
    ifc.in_valid = 1'b1;
    repeat (8) begin
      acc = ifc.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 6) set_fields(2'b10, 5'(idx + 1), 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
      end
    end
    chk("s2_accepted", 32'(idx), 32'd5);
    chk("s2_in_ready", 32'(ifc.in_ready), 32'd0);
    ifc.in_valid = 1'b0;
    chk("s2_hold_we", 32'(ifc.mem_we), 32'd1);
    chk("s2_hold_addr", ifc.mem_addr, 32'h100);
    chk("s2_hold_data", ifc.mem_wdata, 32'h000000B3);
    ifc.mem_ready = 1'b1;
    pulse_finish();
    wait_done("s2");
    chk("s2_nwr", 32'(wr_addr_q.size()), 32'd5);
    if (wr_addr_q.size() == 5) begin
      chk("s2_no_bubble", 32'(wr_cyc_q[4] - wr_cyc_q[0]), 32'd4);
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("s2_addr%0d", i), wr_addr_q[i], 32'h100 + 32'(4 * i));
        chk($sformatf("s2_data%0d", i), wr_data_q[i], exp2_data[i]);
      end
    end
    chk("s2_count", 32'(count), 32'd5);

    // Finish together with the last handshake; done one cycle after last write.
    do_reset();
    ifc.mem_ready = 1'b1;
    pulse_start(32'h0000_0100);
    send(2'b00, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0, 1'b0);
    send(2'b00, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0, 1'b0);
    send(2'b00, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0, 1'b1);
    wait_done("s3");
    chk("s3_nwr", 32'(wr_addr_q.size()), 32'd3);
    if (wr_addr_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("s3_addr%0d", i), wr_addr_q[i], 32'h100 + 32'(4 * i));
        chk($sformatf("s3_data%0d", i), wr_data_q[i], exp3_data[i]);
      end
      chk("s3_done_timing", 32'(done_cyc - wr_cyc_q[2]), 32'd1);
    end
    chk("s3_count", 32'(count), 32'd3);

    // Address wrap; low base bits are dropped.
    do_reset();
    ifc.mem_ready = 1'b1;
    pulse_start(32'hFFFF_FFFE);
    send(2'b10, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0, 1'b0);
    send(2'b10, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0, 1'b1);
    wait_done("s4");
    chk("s4_nwr", 32'(wr_addr_q.size()), 32'd2);
    if (wr_addr_q.size() == 2) begin
      chk("s4_addr0", wr_addr_q[0], 32'hFFFF_FFFC);
      chk("s4_addr1", wr_addr_q[1], 32'h0000_0000);
    end

    // Reset mid-session with words queued; then in_valid in IDLE is ignored.
    do_reset();
    pulse_start(32'h0000_0100);
    send(2'b10, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0, 1'b0);
    send(2'b10, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0, 1'b0);
    send(2'b10, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 13'd0, 1'b0);
    chk("s5_pre_we", 32'(ifc.mem_we), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("s5_we", 32'(ifc.mem_we), 32'd0);
    chk("s5_addr", ifc.mem_addr, 32'd0);
    chk("s5_wdata", ifc.mem_wdata, 32'd0);
    chk("s5_busy", 32'(busy), 32'd0);
    ifc.mem_ready = 1'b1;
    ifc.in_valid = 1'b1;
    pulse_finish();
    repeat (6) @(posedge clk);
    #1;
    chk("s5_idle_ready", 32'(ifc.in_ready), 32'd0);
    ifc.in_valid = 1'b0;
    chk("s5_nwr_idle", 32'(wr_addr_q.size()), 32'd0);
    pulse_start(32'h0000_0200);
    chk("s5_restart_busy", 32'(busy), 32'd1);
    pulse_finish();
    wait_done("s5");
    chk("s5_nwr_flushed", 32'(wr_addr_q.size()), 32'd0);
    chk("s5_count", 32'(count), 32'd0);

    // Odd branch offset: flagged with the range check, truncated without it.
    do_reset();
    ifc.mem_ready = 1'b1;
    pulse_start(32'h0000_0100);
    send(2'b11, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'd3, 1'b1);
    wait_done("s6");
`ifdef IENC_RANGE_CHECK_EN
    chk("s6_err", 32'(err), 32'd1);
    chk("s6_nwr", 32'(wr_addr_q.size()), 32'd0);
    pulse_start(32'h0000_0100);
    chk("s6_err_clr", 32'(err), 32'd0);
    pulse_finish();
    wait_done("s6b");
`else
    chk("s6_err", 32'(err), 32'd0);
    chk("s6_nwr", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() == 1) chk("s6_data", wr_data_q[0], 32'h00208163);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
